nbody_integrator: RTL and testbench

- Downstream stage of the force accumulator (NBodySim).
- Once forces for a timestep are in the shared 80-bit body BRAM, this block walks bodies 0..N-1 and reads each body record and its force word.
- Applies a semi-implicit Euler update: velocity first, then position using the new velocity. Writes the updated record back in place.
- Pulses done so the top-level sequencer can launch the next force pass.

---
 rtl/nbody_integrator_if.sv | 32 +++
 rtl/nbody_integrator.sv | 149 ++++++++++++++
 tb/tb_nbody_integrator.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/nbody_integrator_if.sv
// Bus bundle between nbody_integrator and its sequencer / body BRAM.
//   start    : one-cycle integrate request (sequencer -> integrator)
//   busy     : integrator is mid-pass
//   done     : one-cycle pulse after the last record is written
//   rd_addr  : BRAM read address, rd_data returns one cycle later
//   wr_addr  : BRAM write address
//   wr_data  : BRAM write data
//   wr_en    : BRAM write enable
// master = integrator side, slave = sequencer/BRAM side.
interface nbody_integrator_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 80
) ();
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

  modport master (
    input  start, rd_data,
    output busy, done, rd_addr, wr_addr, wr_data, wr_en
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_addr, wr_addr, wr_data, wr_en
  );
endinterface

// File: rtl/nbody_integrator.sv
// Semi-implicit Euler integrator for the N-body simulator.
// Walks bodies 0..N-1, reads each body record and its force word from the
// shared BRAM, updates velocity then position (using the new velocity) with
// 16-bit saturating arithmetic, and writes the record back in place.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : nbody_integrator_if.master (start/busy/done + BRAM read/write)
// Record : [79:64] pos_x [63:48] pos_y [47:32] vel_x [31:16] vel_y [15:0] mass
// Force  : [31:16] fx [15:0] fy (upper bits ignored)
module nbody_integrator #(
  parameter int N          = 2,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 80,
  parameter int BODY_BASE  = 0,
  parameter int FORCE_BASE = 400,
  parameter int DT_SHIFT   = 4
) (
  input  logic clk,
  input  logic reset,
  nbody_integrator_if.master bus
);

  localparam int IDX_W = $clog2(N) + 1;

  typedef enum logic [2:0] {IDLE, RB, RF, CAP, CALC, WR, DONE} state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]  idx;
  logic              last;
  logic [ADDR_W-1:0] body_addr;
  logic [ADDR_W-1:0] force_addr;

  logic [DATA_W-1:0] body_q;
  logic signed [15:0] fx_q, fy_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic signed [15:0] pos_x, pos_y, vel_x, vel_y;
  logic [15:0]        mass;
  logic signed [15:0] vx_new, vy_new, px_new, py_new;

  // 17-bit signed sum, clamped back into 16 bits on overflow.
  function automatic logic signed [15:0] add_sat(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic signed [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16] != s[15])
      return s[16] ? 16'sh8000 : 16'sh7FFF;
    return s[15:0];
  endfunction

  assign last       = (idx == IDX_W'(N - 1));
  assign body_addr  = ADDR_W'(BODY_BASE) + ADDR_W'(idx);
  assign force_addr = ADDR_W'(FORCE_BASE) + ADDR_W'(idx);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_addr = '0;
    case (state)
      IDLE: if (bus.start) state_next = RB;
      RB: begin
        bus.busy    = 1'b1;
        bus.rd_addr = body_addr;
        state_next  = RF;
      end
      RF: begin
        bus.busy    = 1'b1;
        bus.rd_addr = force_addr;
        state_next  = CAP;
      end
      CAP: begin
        bus.busy   = 1'b1;
        state_next = CALC;
      end
      CALC: begin
        bus.busy   = 1'b1;
        state_next = WR;
      end
      WR: begin
        bus.busy   = 1'b1;
        bus.wr_en  = 1'b1;
        state_next = last ? DONE : RB;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      idx <= '0;
    else if (state == IDLE && bus.start)
      idx <= '0;
    else if (state == WR && !last)
      idx <= idx + 1'b1;
  end

  always_comb begin
    pos_x  = body_q[79:64];
    pos_y  = body_q[63:48];
    vel_x  = body_q[47:32];
    vel_y  = body_q[31:16];
    mass   = body_q[15:0];
    vx_new = add_sat(vel_x, fx_q >>> DT_SHIFT);
    vy_new = add_sat(vel_y, fy_q >>> DT_SHIFT);
    px_new = add_sat(pos_x, vx_new >>> DT_SHIFT);
    py_new = add_sat(pos_y, vy_new >>> DT_SHIFT);
  end

  // rd_data lags rd_addr by one cycle: the body record arrives in RF and the
  // force word in CAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      body_q    <= '0;
      fx_q      <= '0;
      fy_q      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (state == RF)
        body_q <= bus.rd_data;
      if (state == CAP) begin
        fx_q <= bus.rd_data[31:16];
        fy_q <= bus.rd_data[15:0];
      end
      if (state == CALC) begin
        wr_addr_q <= body_addr;
        wr_data_q <= DATA_W'({px_new, py_new, vx_new, vy_new, mass});
      end
    end
  end

  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_nbody_integrator.sv
// Scoreboard bench for nbody_integrator: a one-body instance (u1) and a
// two-body instance with non-zero body base (u2), each backed by a
// synchronous-read BRAM model.
module tb_nbody_integrator;
  localparam int AW  = 15;
  localparam int DW  = 80;
  localparam int BB2 = 32;
  localparam int FB  = 400;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nbody_integrator_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  nbody_integrator_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  nbody_integrator #(.N(1), .ADDR_W(AW), .DATA_W(DW), .BODY_BASE(0),
                     .FORCE_BASE(FB), .DT_SHIFT(4))
    u1 (.clk(clk), .reset(reset), .bus(bus1));

  nbody_integrator #(.N(2), .ADDR_W(AW), .DATA_W(DW), .BODY_BASE(BB2),
                     .FORCE_BASE(FB), .DT_SHIFT(4))
    u2 (.clk(clk), .reset(reset), .bus(bus2));

  logic [DW-1:0] mem1 [0:511];
  logic [DW-1:0] mem2 [0:511];

  always @(posedge clk) begin
    bus1.rd_data <= mem1[bus1.rd_addr[8:0]];
    bus2.rd_data <= mem2[bus2.rd_addr[8:0]];
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_exp_t;

  wr_exp_t q1[$], q2[$];
  int      dq1[$], dq2[$];
  int      t1 = 0, t2 = 0;
  int      checks = 0, failures = 0;
  wr_exp_t e1, e2;
  int      d1, d2;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rec(input int px, input int py, input int vx,
                                        input int vy, input int m);
    return {px[15:0], py[15:0], vx[15:0], vy[15:0], m[15:0]};
  endfunction

  function automatic logic [DW-1:0] fw(input int fx, input int fy);
    return {48'h0, fx[15:0], fy[15:0]};
  endfunction

  // Monitors: every write / done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (bus1.wr_en === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL u1_unexpected_write: addr %h data %h at cycle %0d", bus1.wr_addr, bus1.wr_data, cyc - t1);
      end else begin
        e1 = q1.pop_front();
        chk("u1_wr_addr", DW'(bus1.wr_addr), DW'(e1.addr));
        chk("u1_wr_data", bus1.wr_data, e1.data);
        chk("u1_wr_cycle", DW'(cyc - t1), DW'(e1.cyc));
      end
    end
    if (bus1.done === 1'b1) begin
      if (dq1.size() == 0) begin
        checks++; failures++;
        $display("FAIL u1_unexpected_done: at cycle %0d expected none", cyc - t1);
      end else begin
        d1 = dq1.pop_front();
        chk("u1_done_cycle", DW'(cyc - t1), DW'(d1));
      end
    end
  end

  always @(negedge clk) begin
    if (bus2.wr_en === 1'b1) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL u2_unexpected_write: addr %h data %h at cycle %0d", bus2.wr_addr, bus2.wr_data, cyc - t2);
      end else begin
        e2 = q2.pop_front();
        chk("u2_wr_addr", DW'(bus2.wr_addr), DW'(e2.addr));
        chk("u2_wr_data", bus2.wr_data, e2.data);
        chk("u2_wr_cycle", DW'(cyc - t2), DW'(e2.cyc));
      end
    end
    if (bus2.done === 1'b1) begin
      if (dq2.size() == 0) begin
        checks++; failures++;
        $display("FAIL u2_unexpected_done: at cycle %0d expected none", cyc - t2);
      end else begin
        d2 = dq2.pop_front();
        chk("u2_done_cycle", DW'(cyc - t2), DW'(d2));
      end
    end
  end

  task automatic push2(input int addr, input logic [DW-1:0] data, input int c);
    wr_exp_t e;
    e.addr = AW'(addr);
    e.data = data;
    e.cyc  = c;
    q2.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge of cycle 1.
  task automatic launch2();
    t2 = cyc;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
  endtask

  initial begin
    wr_exp_t e;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    for (int i = 0; i < 512; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", DW'(bus2.busy), DW'(0));
    chk("rst_done", DW'(bus2.done), DW'(0));
    chk("rst_wr_en", DW'(bus2.wr_en), DW'(0));
    chk("rst_rd_addr", DW'(bus2.rd_addr), DW'(0));
    chk("rst_wr_addr", DW'(bus2.wr_addr), DW'(0));
    chk("rst_wr_data", bus2.wr_data, '0);
    chk("rst_u1_busy", DW'(bus1.busy), DW'(0));
    reset = 1'b0;
    @(negedge clk);

    // Single body, N=1
    mem1[0]  = rec(100, -50, 16, 0, 7);
    mem1[FB] = fw(32, -64);
    e.addr = '0;
    e.data = rec(101, -51, 18, -4, 7);
    e.cyc  = 5;
    q1.push_back(e);
    dq1.push_back(6);
    t1 = cyc;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (8) @(negedge clk);

    // N=2 saturation (positive then negative) with busy/rd_addr timing
    mem2[BB2]   = rec(32767, 0, 32760, 0, 3);
    mem2[FB]    = fw(32767, 0);
    mem2[BB2+1] = rec(-32768, 0, -32760, 0, 65535);
    mem2[FB+1]  = fw(-32768, 0);
    push2(BB2,     rec(32767, 0, 32767, 0, 3), 5);
    push2(BB2 + 1, rec(-32768, 0, -32768, 0, 65535), 10);
    dq2.push_back(11);
    chk("busy_c0", DW'(bus2.busy), DW'(0));
    launch2();
    for (int r = 1; r <= 12; r++) begin
      chk($sformatf("busy_c%0d", r), DW'(bus2.busy), DW'((r <= 11) ? 1 : 0));
      if (r == 1) chk("rd_addr_rb", DW'(bus2.rd_addr), DW'(BB2));
      if (r == 2) chk("rd_addr_rf", DW'(bus2.rd_addr), DW'(FB));
      if (r == 3) chk("rd_addr_cap", DW'(bus2.rd_addr), DW'(0));
      if (r == 7) chk("rd_addr_rf1", DW'(bus2.rd_addr), DW'(FB + 1));
      @(negedge clk);
    end

    // Force upper bits ignored; start re-pulsed in cycle 3 is ignored
    mem2[BB2]   = rec(10, 20, 5, -5, 9);
    mem2[FB]    = {48'hFFFF_FFFF_FFFF, 16'h0010, 16'h0020};
    mem2[BB2+1] = rec(10, 20, 5, -5, 9);
    mem2[FB+1]  = fw(16, 32);
    push2(BB2,     rec(10, 19, 6, -3, 9), 5);
    push2(BB2 + 1, rec(10, 19, 6, -3, 9), 10);
    dq2.push_back(11);
    launch2();
    @(negedge clk);
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_after_repulse", DW'(bus2.busy), DW'(0));
    repeat (3) @(negedge clk);

    // Reset during CAP of body 0: no write, no done
    launch2();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", DW'(bus2.busy), DW'(0));
    chk("midrst_done", DW'(bus2.done), DW'(0));
    chk("midrst_wr_en", DW'(bus2.wr_en), DW'(0));
    chk("midrst_wr_addr", DW'(bus2.wr_addr), DW'(0));
    chk("midrst_wr_data", bus2.wr_data, '0);
    repeat (12) @(negedge clk);

    // Full pass after the aborted one
    mem2[BB2]   = rec(-100, 200, -40, 33, 16'h1234);
    mem2[FB]    = fw(-17, 100);
    mem2[BB2+1] = rec(0, 0, 0, 0, 1);
    mem2[FB+1]  = fw(15, -15);
    push2(BB2,     rec(-103, 202, -42, 39, 16'h1234), 5);
    push2(BB2 + 1, rec(0, -1, 0, -1, 1), 10);
    dq2.push_back(11);
    launch2();
    repeat (13) @(negedge clk);

    chk("scoreboard_drained", DW'(q1.size() + q2.size() + dq1.size() + dq2.size()), DW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
